// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI master: FSM encoding, legal key sizes
// and the frame-length helper.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_TX     = 3'd2,
    ST_GAP    = 3'd3,
    ST_RX     = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  // 9 bits covers the longest frame (384 bits) without wrapping.
  localparam int CNT_W = 9;

  function automatic int frame_bits(input int nk);
    return 128 + 32 * nk;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Frame shift register: parallel load, shift-left with serial input,
// MSB presented as the serial output.
module spi_shift_reg #(
  parameter int WIDTH = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], serial_in};
    end
  end

  assign serial_out = q[WIDTH-1];

endmodule

// File: rtl/aes_spi_master.sv
// SPI-style master for an external AES core: sends {data,key}, waits, then
// receives a frame of the same length and keeps its top 128 bits as the result.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int Nk       = 4,
  parameter int WAIT_CYC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [127:0]      data_in,
  input  logic [32*Nk-1:0]  key_in,
  input  logic              miso,
  output logic              spi_enable,
  output logic              mosi,
  output logic              ss,
  output logic              busy,
  output logic              done,
  output logic [127:0]      data_out
);

  localparam int FRAME    = frame_bits(Nk);
  localparam int KEY_BITS = 32 * Nk;
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               mode_reg;
  logic               sr_load, sr_shift, sr_out;
  logic [FRAME-1:0]   sr_q;
  logic               unused_low;

  spi_shift_reg #(.WIDTH(FRAME)) u_shift (
    .clock      (clock),
    .reset      (reset),
    .load       (sr_load),
    .load_data  ({data_in, key_in}),
    .shift      (sr_shift),
    .serial_in  ((state_reg == ST_RX) ? miso : 1'b0),
    .serial_out (sr_out),
    .q          (sr_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_LAUNCH;
          sr_load    = 1'b1;
        end
      end
      ST_LAUNCH: begin
        state_next = ST_TX;
        cnt_next   = FRAME_LOAD;
      end
      ST_TX: begin
        sr_shift = 1'b1;
        if (cnt_reg == '0) begin
          if (WAIT_CYC == 0) begin
            state_next = ST_RX;
            cnt_next   = FRAME_LOAD;
          end else begin
            state_next = ST_GAP;
            cnt_next   = GAP_LOAD;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == '0) begin
          state_next = ST_RX;
          cnt_next   = FRAME_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RX: begin
        sr_shift = 1'b1;
        if (cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The last miso bit lands on the same edge that loads data_out, so the
  // result is taken from the register as it will be after that final shift.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_reg <= 1'b0;
      data_out <= '0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        mode_reg <= mode;
      end
      if (state_reg == ST_RX && cnt_reg == '0) begin
        data_out <= sr_q[FRAME-2:KEY_BITS-1];
      end
    end
  end

  assign unused_low = ^sr_q[KEY_BITS-2:0];

  assign busy       = (state_reg == ST_LAUNCH) || (state_reg == ST_TX) ||
                      (state_reg == ST_GAP)    || (state_reg == ST_RX);
  assign done       = (state_reg == ST_DONE);
  assign spi_enable = (state_reg == ST_LAUNCH);
  assign mosi       = (state_reg == ST_TX) && sr_out;
  assign ss         = busy && mode_reg;

endmodule

// File: tb/tb_aes_spi_master.sv
// Directed bench: Nk=4/WAIT_CYC=4 instance with a behavioural AES slave, plus
// an Nk=8/WAIT_CYC=0 instance for the long-frame, no-gap timing.
module tb_aes_spi_master;

  localparam int FA = 256, WA = 4, DONE_A = 2 + 2 * FA + WA;
  localparam int FB = 384, DONE_B = 2 + 2 * FB;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic         start_a = 0, mode_a = 0, miso_a = 0;
  logic [127:0] data_a = '0, key_a = '0;
  logic         spi_enable_a, mosi_a, ss_a, busy_a, done_a;
  logic [127:0] data_out_a;

  logic         start_b = 0, mode_b = 0, miso_b = 0;
  logic [127:0] data_b = '0;
  logic [255:0] key_b = '0;
  logic         spi_enable_b, mosi_b, ss_b, busy_b, done_b;
  logic [127:0] data_out_b;

  aes_spi_master #(.Nk(4), .WAIT_CYC(WA)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .mode(mode_a),
    .data_in(data_a), .key_in(key_a), .miso(miso_a),
    .spi_enable(spi_enable_a), .mosi(mosi_a), .ss(ss_a), .busy(busy_a),
    .done(done_a), .data_out(data_out_a)
  );

  aes_spi_master #(.Nk(8), .WAIT_CYC(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .mode(mode_b),
    .data_in(data_b), .key_in(key_b), .miso(miso_b),
    .spi_enable(spi_enable_b), .mosi(mosi_b), .ss(ss_b), .busy(busy_b),
    .done(done_b), .data_out(data_out_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Slave knows the FIPS-197 vector; anything else comes back inverted.
  function automatic logic [127:0] slave(input logic m, input logic [127:0] d, input logic [127:0] k);
    if (k == KEY && !m && d == PT) return CT;
    if (k == KEY &&  m && d == CT) return PT;
    return ~d;
  endfunction

  task automatic run_a(input logic m, input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] exp, input bit glitch,
                       input logic [127:0] hold_val, input bit chk_hold);
    logic [255:0] sent;
    logic [255:0] resp;
    int  c = 0;
    bit  seen = 0, ss_ok = 1, ctl_ok = 1, hold_ok = 1;
    resp = '0;
    @(negedge clock);
    start_a = 1; mode_a = m; data_a = d; key_a = k;
    while (!seen && c < DONE_A + 20) begin
      @(negedge clock);
      c++;
      start_a = 0;
      if (glitch && (c == 5 || c == 300)) begin
        start_a = 1; mode_a = ~m; data_a = ~d; key_a = ~k;
      end
      if ((c == 1) !== spi_enable_a) ctl_ok = 0;
      if (c >= 2 && c <= FA + 1) sent[FA - 1 - (c - 2)] = mosi_a;
      else if (mosi_a !== 1'b0) ctl_ok = 0;
      if (c == FA + 1) resp = {slave(ss_a, sent[255:128], sent[127:0]), 128'hdeadbeefcafef00d0123456789abcdef};
      if (c >= 1 && c <= 2 * FA + 1 + WA) begin
        if (ss_a !== m) ss_ok = 0;
        if (busy_a !== 1'b1) ctl_ok = 0;
      end
      if (c >= FA + 2 + WA && c <= 2 * FA + 1 + WA) miso_a = resp[FA - 1 - (c - (FA + 2 + WA))];
      else miso_a = 1'b0;
      if (chk_hold && done_a !== 1'b1 && data_out_a !== hold_val) hold_ok = 0;
      if (done_a === 1'b1) seen = 1;
    end
    $display("xfer mode=%0d data=%h done_cycle=%0d data_out=%h", m, d, seen ? c : -1, data_out_a);
    check("done_cycle", seen ? c : 0, DONE_A);
    check("mosi_stream", sent, {d, k});
    check("data_out", data_out_a, exp);
    check("busy_in_done", busy_a, 1'b0);
    check("ss_in_done", ss_a, 1'b0);
    check("ss_follows_mode", ss_ok, 1'b1);
    check("ctl_outputs", ctl_ok, 1'b1);
    if (chk_hold) check("data_out_hold", hold_ok, 1'b1);
  endtask

  typedef struct {
    logic         m;
    logic [127:0] d;
    logic [127:0] k;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[3];

  initial begin
    logic [127:0] prev;
    logic [383:0] sent_b;
    logic [383:0] resp_b;
    int  c;
    bit  seen, quiet;

    vecs[0] = '{1'b0, PT, KEY, CT};
    vecs[1] = '{1'b1, CT, KEY, PT};
    vecs[2] = '{1'b0, {16{8'ha5}}, KEY, {16{8'h5a}}};

    repeat (3) @(negedge clock);
    check("rst_spi_enable", spi_enable_a, 1'b0);
    check("rst_mosi", mosi_a, 1'b0);
    check("rst_ss", ss_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_data_out", data_out_a, 128'h0);
    reset = 1;
    repeat (2) @(negedge clock);

    // Back-to-back: each vector starts in the cycle after the previous done.
    prev = '0;
    for (int i = 0; i < 3; i++) begin
      run_a(vecs[i].m, vecs[i].d, vecs[i].k, vecs[i].exp, 1'b0, prev, i > 0);
      prev = vecs[i].exp;
    end

    // Extra start pulses at cycles 5 and 300 with different inputs.
    run_a(1'b0, PT, KEY, CT, 1'b1, prev, 1'b1);

    // Start during the DONE cycle must be dropped.
    start_a = 1; mode_a = 1;
    @(negedge clock);
    start_a = 0;
    check("done_start_busy", busy_a, 1'b0);
    check("done_start_launch", spi_enable_a, 1'b0);
    check("single_done", done_a, 1'b0);
    repeat (3) @(negedge clock);
    check("done_start_idle", busy_a, 1'b0);

    // Asynchronous reset at TX cycle 100 of a decrypt transfer.
    @(negedge clock);
    start_a = 1; mode_a = 1; data_a = CT; key_a = KEY;
    @(negedge clock);
    start_a = 0;
    repeat (101) @(negedge clock);
    check("pre_abort_busy", busy_a, 1'b1);
    check("pre_abort_ss", ss_a, 1'b1);
    reset = 0;
    #1;
    check("abort_outputs", {spi_enable_a, mosi_a, ss_a, busy_a, done_a}, 5'b0);
    check("abort_data_out", data_out_a, 128'h0);
    @(negedge clock);
    reset = 1;
    quiet = 1;
    repeat (600) begin
      @(negedge clock);
      if (done_a !== 1'b0 || busy_a !== 1'b0) quiet = 0;
    end
    $display("abort: quiet=%0d", quiet);
    check("abort_no_done", quiet, 1'b1);
    run_a(1'b1, CT, KEY, PT, 1'b0, 128'h0, 1'b1);

    // Nk=8, no gap: 384-bit frames, done 770 cycles after start.
    resp_b = {128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, {8{32'h13579bdf}}};
    @(negedge clock);
    start_b = 1; mode_b = 0; data_b = PT;
    key_b = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    c = 0; seen = 0; sent_b = '0;
    while (!seen && c < DONE_B + 20) begin
      @(negedge clock);
      c++;
      start_b = 0;
      if (c >= 2 && c <= FB + 1) sent_b[FB - 1 - (c - 2)] = mosi_b;
      if (c >= FB + 2 && c <= 2 * FB + 1) miso_b = resp_b[FB - 1 - (c - (FB + 2))];
      else miso_b = 1'b0;
      if (done_b === 1'b1) seen = 1;
    end
    $display("xfer nk8 done_cycle=%0d data_out=%h", seen ? c : -1, data_out_b);
    check("nk8_done_cycle", seen ? c : 0, DONE_B);
    check("nk8_mosi_stream", sent_b, {PT, key_b});
    check("nk8_data_out", data_out_b, resp_b[383:256]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
